uart_prog_loader: RTL and testbench

- Upstream stage of the CPU. Receives a program image over a UART RX line and packs the bytes into 32-bit little-endian words.
- Each word is presented on UartData/UartAddress with a one-cycle write strobe into instruction memory.
- UartOver is raised once the load completes; the CPU is held until then.
- The loader runs on the memory clock domain that also clocks the instruction memory.

---
 rtl/uart_prog_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// -----------------------------------------------------------------------------
// uart_prog_loader
//
// Receives a program image over an 8N1 UART line and packs the bytes into
// 32-bit little-endian words. Each completed word is presented with a
// one-cycle write strobe for the instruction memory. The load ends when the
// line has been idle for IDLE_BITS bit periods, with at least one word
// written, or as soon as MAX_WORDS words have been written. The CPU is held
// until UartOver rises.
//
// Ports:
//   clk          in   loader / instruction-memory clock
//   reset        in   asynchronous active-low reset (0 = reset)
//   rx           in   UART receive line, asynchronous, idles high
//   start        in   single-cycle pulse that (re)starts a load
//   UartData     out  assembled instruction word
//   UartAddress  out  byte address of UartData
//   UartWe       out  one-cycle write strobe (data/address valid while high)
//   UartOver     out  load complete, sticky until the next start
//   frame_err    out  sticky: bad stop bit or partial trailing word
//   busy         out  high while a load is in progress
// -----------------------------------------------------------------------------
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 200,
  parameter int          IDLE_BITS    = 64,
  parameter int          MAX_WORDS    = 16384,
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        start,
  output logic [31:0] UartData,
  output logic [31:0] UartAddress,
  output logic        UartWe,
  output logic        UartOver,
  output logic        frame_err,
  output logic        busy
);

  localparam int BIT_CNT_W  = $clog2(CLKS_PER_BIT + 1);
  localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
  localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);
  localparam int WCNT_W     = $clog2(MAX_WORDS + 1);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] HALF_LAST = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDLE_W-1:0]    IDLE_END  = IDLE_W'(IDLE_LIMIT);
  localparam logic [WCNT_W-1:0]    WORDS_END = WCNT_W'(MAX_WORDS);

  // ---------------------------------------------------------------------------
  // rx synchroniser
  // ---------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_sync;

  // NOTE: the synchroniser resets to the idle line level (1); resetting it to
  // 0 would look like a start bit the moment reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values
      // at the same edge, which is what turns this into a two-stage chain.
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // RX byte receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t             r_rx_state;
  logic [BIT_CNT_W-1:0]  r_bit_clk;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_shift;
  logic                  r_stop_hold;   // bad stop seen, waiting for line high
  logic                  r_byte_valid;
  logic                  r_stop_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state   <= R_IDLE;
      r_bit_clk    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_stop_hold  <= 1'b0;
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
      case (r_rx_state)
        R_IDLE: begin
          r_bit_clk <= '0;
          if (!r_rx_sync) r_rx_state <= R_START;
        end

        // Re-check the start bit half a bit in; a short low pulse is a glitch.
        R_START: begin
          if (r_bit_clk == HALF_LAST) begin
            r_bit_clk <= '0;
            r_bit_idx <= '0;
            r_rx_state <= r_rx_sync ? R_IDLE : R_DATA;
          end else begin
            r_bit_clk <= r_bit_clk + 1'b1;
          end
        end

        // From mid-start, every full bit period lands in the middle of a bit.
        R_DATA: begin
          if (r_bit_clk == BIT_LAST) begin
            r_bit_clk <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};  // LSB first
            if (r_bit_idx == 3'd7) r_rx_state <= R_STOP;
            else                   r_bit_idx  <= r_bit_idx + 1'b1;
          end else begin
            r_bit_clk <= r_bit_clk + 1'b1;
          end
        end

        R_STOP: begin
          if (r_stop_hold) begin
            // Don't re-arm on a line that is still low, or the low level
            // would be taken as another start bit.
            if (r_rx_sync) begin
              r_stop_hold <= 1'b0;
              r_rx_state  <= R_IDLE;
            end
          end else if (r_bit_clk == BIT_LAST) begin
            r_bit_clk <= '0;
            if (r_rx_sync) begin
              r_byte_valid <= 1'b1;
              r_rx_state   <= R_IDLE;
            end else begin
              r_stop_err  <= 1'b1;
              r_stop_hold <= 1'b1;
            end
          end else begin
            r_bit_clk <= r_bit_clk + 1'b1;
          end
        end

        default: r_rx_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Word packer / loader control
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {L_WAIT, L_LOAD, L_DONE} ld_state_t;

  ld_state_t          r_ld_state;
  logic [23:0]        r_word;        // bytes 0..2 of the word being built
  logic [1:0]         r_byte_idx;
  logic [WCNT_W-1:0]  r_word_cnt;
  logic [31:0]        r_addr;
  logic [IDLE_W-1:0]  r_idle_cnt;
  logic [31:0]        r_data;
  logic [31:0]        r_address;
  logic               r_we;
  logic               r_over;
  logic               r_frame_err;
  logic               r_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_state  <= L_WAIT;
      r_word      <= '0;
      r_byte_idx  <= '0;
      r_word_cnt  <= '0;
      r_addr      <= ADDR_BASE;
      r_idle_cnt  <= '0;
      r_data      <= '0;
      r_address   <= ADDR_BASE;
      r_we        <= 1'b0;
      r_over      <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      // start has priority over everything, including a byte in the same cycle.
      if (start) begin
        r_ld_state  <= L_LOAD;
        r_over      <= 1'b0;
        r_frame_err <= 1'b0;
        r_busy      <= 1'b1;
        r_addr      <= ADDR_BASE;
        r_byte_idx  <= '0;
        r_word_cnt  <= '0;
        r_idle_cnt  <= '0;
      end else if (r_ld_state == L_LOAD) begin
        if (r_word_cnt == WORDS_END) begin
          // Evaluated in the strobe cycle of the last word, so UartOver rises
          // the cycle after it and the two are never high together.
          r_ld_state <= L_DONE;
          r_over     <= 1'b1;
          r_busy     <= 1'b0;
        end else if (r_byte_valid) begin
          r_idle_cnt <= '0;
          r_byte_idx <= r_byte_idx + 1'b1;  // wraps 3 -> 0
          case (r_byte_idx)
            2'd0: r_word[7:0]   <= r_shift;
            2'd1: r_word[15:8]  <= r_shift;
            2'd2: r_word[23:16] <= r_shift;
            default: begin
              r_data     <= {r_shift, r_word};
              r_address  <= r_addr;
              r_we       <= 1'b1;
              r_addr     <= r_addr + 32'd4;
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          endcase
        end else if (r_idle_cnt == IDLE_END) begin
          r_idle_cnt <= '0;
          // With nothing written yet the host simply hasn't started sending.
          if (r_word_cnt != '0) begin
            r_ld_state <= L_DONE;
            r_over     <= 1'b1;
            r_busy     <= 1'b0;
            if (r_byte_idx != 2'd0) r_frame_err <= 1'b1;
          end
        end else begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end

        if (r_stop_err) r_frame_err <= 1'b1;
      end
    end
  end

  assign UartData    = r_data;
  assign UartAddress = r_address;
  assign UartWe      = r_we;
  assign UartOver    = r_over;
  assign frame_err   = r_frame_err;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_prog_loader
//
// Directed bench for uart_prog_loader with CLKS_PER_BIT = 8. Two instances
// share the stimulus: dut uses the default MAX_WORDS, dut2 uses MAX_WORDS = 2.
// A negedge monitor records every write strobe; the directed sequence compares
// recorded writes and output levels against hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_prog_loader;

  localparam int CPB       = 8;
  localparam int IDLE_BITS = 64;

  logic        clk;
  logic        reset;
  logic        rx;
  logic        start;

  logic [31:0] d1_data, d1_addr;
  logic        d1_we, d1_over, d1_ferr, d1_busy;
  logic [31:0] d2_data, d2_addr;
  logic        d2_we, d2_over, d2_ferr, d2_busy;

  int errors = 0;
  int checks = 0;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IDLE_BITS)) dut (
    .clk(clk), .reset(reset), .rx(rx), .start(start),
    .UartData(d1_data), .UartAddress(d1_addr), .UartWe(d1_we),
    .UartOver(d1_over), .frame_err(d1_ferr), .busy(d1_busy)
  );

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IDLE_BITS), .MAX_WORDS(2)) dut2 (
    .clk(clk), .reset(reset), .rx(rx), .start(start),
    .UartData(d2_data), .UartAddress(d2_addr), .UartWe(d2_we),
    .UartOver(d2_over), .frame_err(d2_ferr), .busy(d2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Write monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  logic [31:0] wr_data[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr2_addr[$];
  int          cyc = 0;
  int          last_we2_cyc = -10;
  int          over2_rise_cyc = -20;
  logic        over2_q = 1'b0;
  int          both_high = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (d1_we) begin
      wr_data.push_back(d1_data);
      wr_addr.push_back(d1_addr);
    end
    if (d2_we) begin
      wr2_addr.push_back(d2_addr);
      last_we2_cyc = cyc;
    end
    if (d2_over && !over2_q) over2_rise_cyc = cyc;
    over2_q = d2_over;
    if ((d1_we && d1_over) || (d2_we && d2_over)) both_high = both_high + 1;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = stop_bit;
    wait_clks(CPB);
    rx = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  logic [7:0]  prog_bytes [16] = '{8'h93, 8'h00, 8'h50, 8'h00,
                                   8'h13, 8'h01, 8'h30, 8'h00,
                                   8'hB3, 8'h81, 8'h20, 8'h00,
                                   8'h23, 8'h20, 8'h30, 8'h00};
  logic [31:0] prog_words [4] = '{32'h00500093, 32'h00300113,
                                  32'h002081B3, 32'h00302023};
  int base;
  int base2;

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    start = 1'b0;
    wait_clks(3);

    check("rst_data", d1_data, 32'h0);
    check("rst_addr", d1_addr, 32'h0);
    check("rst_we",   32'(d1_we),   32'h0);
    check("rst_over", 32'(d1_over), 32'h0);
    check("rst_ferr", 32'(d1_ferr), 32'h0);
    check("rst_busy", 32'(d1_busy), 32'h0);

    reset = 1'b1;
    wait_clks(2);

    // Single word
    pulse_start();
    check("t1_busy_after_start", 32'(d1_busy), 32'h1);
    base = wr_data.size();
    send_byte(8'h93, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h50, 1'b1);
    check("t1_no_write_before_byte3", 32'(wr_data.size() - base), 32'd0);
    send_byte(8'h00, 1'b1);
    wait_clks(4);
    check("t1_write_count", 32'(wr_data.size() - base), 32'd1);
    check("t1_data", wr_data[base], 32'h00500093);
    check("t1_addr", wr_addr[base], 32'h0);
    check("t1_busy", 32'(d1_busy), 32'h1);

    // Four words, then the line goes idle
    pulse_start();
    base = wr_data.size();
    for (int i = 0; i < 16; i++) send_byte(prog_bytes[i], 1'b1);
    wait_clks(4);
    check("t2_write_count", 32'(wr_data.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_data%0d", i), wr_data[base + i], prog_words[i]);
      check($sformatf("t2_addr%0d", i), wr_addr[base + i], 32'(4 * i));
    end
    check("t2_over_before_idle", 32'(d1_over), 32'h0);
    wait_clks(IDLE_BITS * CPB + 60);
    check("t2_over", 32'(d1_over), 32'h1);
    check("t2_busy", 32'(d1_busy), 32'h0);
    check("t2_ferr", 32'(d1_ferr), 32'h0);

    // Bad stop bit on the third byte: that byte is dropped
    pulse_start();
    check("t3_over_cleared", 32'(d1_over), 32'h0);
    base = wr_data.size();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b0);
    wait_clks(2 * CPB);
    check("t3_ferr", 32'(d1_ferr), 32'h1);
    check("t3_no_write", 32'(wr_data.size() - base), 32'd0);
    send_byte(8'hDD, 1'b1);
    send_byte(8'hEE, 1'b1);
    wait_clks(4);
    check("t3_write_count_a", 32'(wr_data.size() - base), 32'd1);
    check("t3_data_a", wr_data[base], 32'hEEDDBBAA);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    wait_clks(4);
    check("t3_write_count_b", 32'(wr_data.size() - base), 32'd2);
    check("t3_data_b", wr_data[base + 1], 32'h44332211);
    check("t3_addr_b", wr_addr[base + 1], 32'h4);
    check("t3_ferr_sticky", 32'(d1_ferr), 32'h1);

    // Start-bit glitch, then a word plus a partial trailing word
    pulse_start();
    check("t4_ferr_cleared", 32'(d1_ferr), 32'h0);
    base = wr_data.size();
    rx = 1'b0;
    wait_clks(2);
    rx = 1'b1;
    wait_clks(3 * CPB);
    check("t4_glitch_no_write", 32'(wr_data.size() - base), 32'd0);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
    wait_clks(IDLE_BITS * CPB + 60);
    check("t4_write_count", 32'(wr_data.size() - base), 32'd1);
    check("t4_data", wr_data[base], 32'h04030201);
    check("t4_over", 32'(d1_over), 32'h1);
    check("t4_ferr", 32'(d1_ferr), 32'h1);
    check("t4_busy", 32'(d1_busy), 32'h0);

    // MAX_WORDS = 2 instance: the third word produces no strobe
    pulse_start();
    base  = wr_data.size();
    base2 = wr2_addr.size();
    for (int i = 0; i < 12; i++) send_byte(8'(8'h20 + i), 1'b1);
    wait_clks(4);
    check("t5_write_count", 32'(wr2_addr.size() - base2), 32'd2);
    check("t5_addr0", wr2_addr[base2], 32'h0);
    check("t5_addr1", wr2_addr[base2 + 1], 32'h4);
    check("t5_over_latency", 32'(over2_rise_cyc), 32'(last_we2_cyc + 1));
    check("t5_over", 32'(d2_over), 32'h1);
    check("t5_busy", 32'(d2_busy), 32'h0);
    check("t5_unlimited_count", 32'(wr_data.size() - base), 32'd3);

    // Reset in the middle of a byte of word 1
    pulse_start();
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h9A, 1'b1);
    send_byte(8'hBC, 1'b1);
    rx = 1'b0;
    wait_clks(3 * CPB);
    check("t6_pre_data", d1_data, 32'h12345678);
    check("t6_pre_busy", 32'(d1_busy), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_data", d1_data, 32'h0);
    check("t6_rst_addr", d1_addr, 32'h0);
    check("t6_rst_we",   32'(d1_we),   32'h0);
    check("t6_rst_over", 32'(d1_over), 32'h0);
    check("t6_rst_ferr", 32'(d1_ferr), 32'h0);
    check("t6_rst_busy", 32'(d1_busy), 32'h0);
    rx = 1'b1;
    wait_clks(3);
    reset = 1'b1;
    wait_clks(2);
    pulse_start();
    base = wr_data.size();
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hD4, 1'b1);
    wait_clks(4);
    check("t6_write_count", 32'(wr_data.size() - base), 32'd1);
    check("t6_addr", wr_addr[base], 32'h0);
    check("t6_data", wr_data[base], 32'hD4C3B2A1);

    check("we_over_exclusive", 32'(both_high), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
